// File: rtl/inst_fetch_queue_pkg.sv
// Shared configuration for the instruction fetch queue: default widths, reset PC
// and FSM state encodings.
package inst_fetch_queue_pkg;

    localparam int          ADDR_W_DEF   = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DROP = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Memory, decoder and redirect signals between the fetch queue (master) and
// its surroundings (slave).
interface inst_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_result;
    logic              mem_ready;

    logic              inst_valid;
    logic [ADDR_W-1:0] inst_addr;
    logic [INST_W-1:0] inst_result;
    logic              dc_ok;

    logic              dc_redirect;
    logic [ADDR_W-1:0] dc_next_pc;
    logic              rob_clear;
    logic [ADDR_W-1:0] rob_next_pc;

    modport master (
        output mem_valid, mem_addr, inst_valid, inst_addr, inst_result,
        input  mem_result, mem_ready, dc_ok, dc_redirect, dc_next_pc,
               rob_clear, rob_next_pc
    );

    modport slave (
        input  mem_valid, mem_addr, inst_valid, inst_addr, inst_result,
        output mem_result, mem_ready, dc_ok, dc_redirect, dc_next_pc,
               rob_clear, rob_next_pc
    );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Circular buffer of (PC, instruction) pairs with push, pop and flush.
// Callers gate push/pop/flush; pop is only requested when count is non-zero.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int IW    = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [AW-1:0]            push_addr,
    input  logic [IW-1:0]            push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [AW-1:0]            head_addr,
    output logic [IW-1:0]            head_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [IW-1:0]    data_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk_in) begin
        if (push && !flush) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_addr = (count_q != '0) ? addr_q[rd_ptr_q] : '0;
    assign head_data = (count_q != '0) ? data_q[rd_ptr_q] : '0;
    assign count     = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: one outstanding memory request at a time,
// results queued in order for the decoder, with flush on redirect/mispredict.
//   state   | meaning
//   IDLE    | no request outstanding
//   REQ     | request outstanding, response will be queued
//   DROP    | stale request outstanding, response discarded
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                 IQ_DEPTH = 4,
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 INST_W   = INST_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    inst_fetch_queue_if.master  bus
);
    localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    cnt_after;
    logic              push, pop, flush;

    assign pc_inc    = pc_q + ADDR_W'(4);
    assign cnt_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        push        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        // rob_clear outranks a decoder-predicted redirect
        redirect_pc = bus.rob_clear ? bus.rob_next_pc : bus.dc_next_pc;
        if (rdy_in) begin
            flush = bus.rob_clear | bus.dc_redirect;
            if (flush) begin
                pc_d = redirect_pc;
                if (state_q != ST_IDLE)
                    state_d = bus.mem_ready ? ST_IDLE : ST_DROP;
            end else begin
                pop = bus.dc_ok && (count != '0);
                case (state_q)
                    ST_IDLE: begin
                        if (count < CNT_W'(IQ_DEPTH)) begin
                            state_d    = ST_REQ;
                            req_addr_d = pc_q;
                        end
                    end
                    ST_REQ: begin
                        if (bus.mem_ready) begin
                            push = 1'b1;
                            pc_d = pc_inc;
                            if (cnt_after < (CNT_W+1)'(IQ_DEPTH)) begin
                                state_d    = ST_REQ;
                                req_addr_d = pc_inc;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                    ST_DROP: begin
                        if (bus.mem_ready) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (IQ_DEPTH),
        .AW    (ADDR_W),
        .IW    (INST_W)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_addr (pc_q),
        .push_data (bus.mem_result),
        .pop       (pop),
        .flush     (flush),
        .head_addr (bus.inst_addr),
        .head_data (bus.inst_result),
        .count     (count)
    );

    assign bus.mem_valid  = (state_q != ST_IDLE);
    assign bus.mem_addr   = req_addr_q;
    assign bus.inst_valid = (count != '0);

endmodule
